// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, addresses the instruction memory
// and buffers fetched {PC, instruction, PC+4} entries in a small FIFO that
// decode drains with a valid/ready handshake. Redirects flush the queue.
module fetch_queue_unit #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic                         CLK,
    input  logic                         Reset_L,
    input  logic [ADDR_W-1:0]            startPC,
    input  logic                         fetch_en,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_target,
    output logic                         if_valid,
    input  logic                         id_ready,
    output logic [ADDR_W-1:0]            if_pc,
    output logic [ADDR_W-1:0]            if_pcplus4,
    output logic [INSTR_W-1:0]           if_instr,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  r_pc;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [ADDR_W-1:0]  r_pcp4_mem  [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];

    logic               w_pop;
    logic               w_push;
    logic               w_not_empty;
    logic               w_not_full;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic               w_unused;

    // Low address bits are always forced to word alignment, so they are never consumed.
    assign w_unused = &{1'b0, startPC[1:0], redirect_target[1:0]};

    assign w_not_empty = (r_count != '0);
    assign w_not_full  = (r_count < CNT_W'(DEPTH));
    assign w_pc_plus4  = r_pc + ADDR_W'(4);

    // A redirect suppresses both sides of the handshake; a pop frees a slot so a
    // full queue can still accept a fetch in the same cycle.
    assign w_pop  = w_not_empty & id_ready & ~redirect_valid;
    assign w_push = fetch_en & ~redirect_valid & (w_not_full | w_pop);

    // PC, pointers and occupancy; redirect outranks everything except reset.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_pc     <= {startPC[ADDR_W-1:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pc     <= {redirect_target[ADDR_W-1:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= w_pc_plus4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful under the valid count, so no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_pc;
            r_pcp4_mem[r_wr_ptr]  <= w_pc_plus4;
            r_instr_mem[r_wr_ptr] <= imem_data;
        end
    end

    // Head of queue is presented straight from storage and forced to zero when empty.
    always_comb begin
        imem_addr   = r_pc;
        if_valid    = w_not_empty;
        queue_count = r_count;
        if_pc       = '0;
        if_pcplus4  = '0;
        if_instr    = '0;
        if (w_not_empty) begin
            if_pc      = r_pc_mem[r_rd_ptr];
            if_pcplus4 = r_pcp4_mem[r_rd_ptr];
            if_instr   = r_instr_mem[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus a randomized run, with a
// queue-based reference model feeding a scoreboard that a monitor drains.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [31:0] startPC;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
    logic [31:0] if_instr;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    int          m_count;
    logic [31:0] m_pc;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // Behavioural instruction memory
    assign imem_data = imem_f(imem_addr);

    fetch_queue_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .Reset_L(Reset_L),
        .startPC(startPC),
        .fetch_en(fetch_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .if_valid(if_valid),
        .id_ready(id_ready),
        .if_pc(if_pc),
        .if_pcplus4(if_pcplus4),
        .if_instr(if_instr),
        .queue_count(queue_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of fetched entries and a PC, advanced per the rules
    always @(posedge CLK or negedge Reset_L) begin
        bit pop, push;
        if (!Reset_L) begin
            exp_q.delete();
            m_count = 0;
            m_pc = startPC & ~32'h3;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_count = 0;
            m_pc = redirect_target & ~32'h3;
        end else begin
            pop  = (m_count != 0) && id_ready;
            push = fetch_en && ((m_count < DEPTH) || pop);
            if (push) begin
                exp_q.push_back('{pc: m_pc, instr: imem_f(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_count = m_count + int'(push) - int'(pop);
        end
    end

    // Monitor: compare presented head against scoreboard, retire on handshake
    always @(negedge CLK) begin
        ent_t e;
        check("mon_count", 32'(queue_count), 32'(m_count));
        check("mon_valid", 32'(if_valid), 32'(m_count != 0));
        check("mon_imem_addr", imem_addr, m_pc);
        if (if_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_head actual=valid expected=empty at %0t", $time);
            end else begin
                e = exp_q[0];
                check("mon_if_pc", if_pc, e.pc);
                check("mon_if_instr", if_instr, e.instr);
                check("mon_if_pcplus4", if_pcplus4, e.pc + 32'd4);
                if (id_ready && !redirect_valid && Reset_L)
                    void'(exp_q.pop_front());
            end
        end else begin
            check("mon_empty_pc", if_pc, 32'h0);
            check("mon_empty_instr", if_instr, 32'h0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] spc);
        Reset_L = 1'b0;
        startPC = spc;
        tick();
        tick();
    endtask

    initial begin
        Reset_L = 1'b1;
        startPC = 32'h100;
        fetch_en = 1'b1;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        #2;

        // Reset from 0x100, streaming fetch and decode
        do_reset(32'h100);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_count", 32'(queue_count), 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_pcplus4", if_pcplus4, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h100);
        Reset_L = 1'b1;
        check("rel_valid", 32'(if_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_valid", 32'(if_valid), 32'h1);
            check("seq_if_pc", if_pc, 32'h100 + 32'(4 * i));
            check("seq_if_pcplus4", if_pcplus4, 32'h104 + 32'(4 * i));
        end

        // Fill to DEPTH with decode stalled
        id_ready = 1'b0;
        do_reset(32'h0);
        Reset_L = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("fill_count", 32'(queue_count), 32'(i));
        end
        tick();
        check("full_count", 32'(queue_count), 32'd4);
        check("full_imem_addr", imem_addr, 32'h10);
        check("full_if_pc", if_pc, 32'h0);

        // One pop while full: simultaneous push keeps it full
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("pp_count", 32'(queue_count), 32'd4);
        check("pp_if_pc", if_pc, 32'h4);
        check("pp_imem_addr", imem_addr, 32'h14);

        // Drain to 3 entries, then redirect to a misaligned target
        fetch_en = 1'b0;
        id_ready = 1'b1;
        tick();
        check("drain_count", 32'(queue_count), 32'd3);
        fetch_en = 1'b1;
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_2003;
        tick();
        redirect_valid = 1'b0;
        check("redir_count", 32'(queue_count), 32'd0);
        check("redir_valid", 32'(if_valid), 32'h0);
        check("redir_imem_addr", imem_addr, 32'h2000);
        tick();
        check("redir_if_pc", if_pc, 32'h2000);
        check("redir_count1", 32'(queue_count), 32'd1);

        // PC wrap at the top of the address space
        id_ready = 1'b1;
        do_reset(32'hFFFF_FFF8);
        Reset_L = 1'b1;
        tick();
        check("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        check("wrap_pcplus4", if_pcplus4, 32'h0);
        tick();
        check("wrap_pc2", if_pc, 32'h0);

        // Asynchronous reset between edges with entries queued
        id_ready = 1'b0;
        do_reset(32'h40);
        Reset_L = 1'b1;
        tick();
        tick();
        tick();
        check("arst_pre_count", 32'(queue_count), 32'd3);
        #2;
        Reset_L = 1'b0;
        #1;
        check("arst_valid", 32'(if_valid), 32'h0);
        check("arst_count", 32'(queue_count), 32'd0);
        check("arst_imem_addr", imem_addr, 32'h40);
        tick();
        Reset_L = 1'b1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!Reset_L) begin
                Reset_L = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                startPC = $urandom();
                Reset_L = 1'b0;
            end
            fetch_en        = ($urandom_range(0, 9) < 8);
            id_ready        = ($urandom_range(0, 9) < 6);
            redirect_valid  = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom();
        end
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined MIPS core. It replaces the single-register PC/next-PC logic of the single-cycle datapath.
- Holds the PC, drives the combinational InstructionMemory address, and buffers fetched {PC, instruction, PC+4} entries in a DEPTH-entry FIFO.
- Decode pops entries with a valid/ready handshake, so decode stalls do not stop fetch until the queue is full.
- Branch and jump resolution later in the pipeline redirect the PC and flush the queue.

Parameters:
- ADDR_W, 32, PC/address width in bits (>=8).
- INSTR_W, 32, instruction width in bits.
- DEPTH, 4, prefetch queue entries (power of two, >=2).

Ports:
- CLK  input  1  clock. All state updates on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- startPC  input  ADDR_W  PC value loaded during reset.
- fetch_en  input  1  enables fetching. When 0, no push and PC holds.
- imem_addr  output  ADDR_W  address to InstructionMemory; always equals PC.
- imem_data  input  INSTR_W  instruction returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump taken; flush and reload PC.
- redirect_target  input  ADDR_W  new PC; bits [1:0] ignored (forced 0).
- if_valid  output  1  queue head holds a valid entry.
- id_ready  input  1  decode accepts the head entry this cycle.
- if_pc  output  ADDR_W  PC of head entry.
- if_pcplus4  output  ADDR_W  if_pc + 4, modulo 2^ADDR_W.
- if_instr  output  INSTR_W  instruction of head entry.
- queue_count  output  clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (Reset_L=0, asynchronous): PC <= {startPC[ADDR_W-1:2], 2'b00}; read/write pointers and count cleared; if_valid=0.
- Reset values of head outputs: if_pc=0, if_pcplus4=0, if_instr=0, queue_count=0.
- Reset may assert mid-operation: all entries are discarded immediately, with no partial push or pop.
- Head outputs are registered storage read at the read pointer. When the queue is empty, if_pc, if_pcplus4 and if_instr are driven to 0.
- pop = if_valid & id_ready & ~redirect_valid.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop). A push is therefore allowed when full if a pop occurs in the same cycle, sustaining 1 instruction/cycle.
- On push: the entry {PC, imem_data, PC+4} is written at the write pointer, and PC <= PC+4.
- PC wraps modulo 2^ADDR_W; e.g. 0xFFFFFFFC -> 0x00000000 for ADDR_W=32.
- No push: PC holds.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- Fetch-to-decode latency: an instruction fetched at edge N is visible at the head after edge N, if the queue was empty.
- Redirect has highest priority. At the edge with redirect_valid=1:
  - count <= 0 and pointers reset;
  - PC <= {redirect_target[ADDR_W-1:2], 2'b00};
  - no push and no pop occur;
  - if_valid=0 in the following cycle.
- The first target entry appears one edge after that, provided fetch_en=1.
- redirect_valid held for several cycles: the PC reloads every cycle and the queue stays empty.
- fetch_en=0 does not block pops; the queue drains normally.
- Invariants: queue_count <= DEPTH always; if_valid == (queue_count != 0).

Test Plan:
- Reset with startPC=0x00000100, fetch_en=1, id_ready=1. Required: if_valid rises one edge after reset release; if_pc sequence 0x100, 0x104, 0x108; if_pcplus4 = if_pc+4.
- DEPTH=4, id_ready=0 from reset, startPC=0. Required: queue_count goes 1, 2, 3, 4 then holds; imem_addr holds at 0x10; head stays at if_pc=0x0.
- Full queue (count=4), then id_ready=1 for one cycle. Required: simultaneous push/pop keeps count=4; head advances to 0x4; imem_addr=0x14.
- Queue with 3 entries; assert redirect_valid=1 with redirect_target=0x0000_2003 for one cycle. Required: next cycle count=0, if_valid=0, imem_addr=0x2000; following cycle if_pc=0x2000.
- startPC=0xFFFFFFF8, id_ready=1. Required: if_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; if_pcplus4 of 0xFFFFFFFC equals 0x0.
- Drop Reset_L asynchronously between edges with count=3, startPC=0x40. Required: if_valid=0, queue_count=0, imem_addr=0x40 before the next clock edge.
